// File: rtl/qam_demodulator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qam_demodulator_pkg
//  Description : Constants and types shared by the QAM modulator and
//                demodulator paths: default symbol length, accumulator
//                width, sample/product widths, the bit positions of the
//                sine/cosine signs inside a 2-bit symbol, and the
//                demodulator state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package qam_demodulator_pkg;

    localparam int SPS_DEF   = 16;   // samples per symbol
    localparam int ACC_W_DEF = 40;   // 32-bit product + log2(256) growth
    localparam int SAMPLE_W  = 16;   // sample / reference width
    localparam int PROD_W    = 32;   // full signed 16x16 product width

    // Bit positions inside sym_out / elojel_sin_cos (1 = negative)
    localparam int SIN_BIT   = 1;
    localparam int COS_BIT   = 0;

    typedef enum logic [0:0] {
        ST_HUNT  = 1'b0,             // waiting for the first sym_sync
        ST_TRACK = 1'b1              // symbol-locked, accumulating
    } dmd_state_e;

endpackage : qam_demodulator_pkg
`default_nettype wire

// File: rtl/qam_demodulator_p2s.sv
`default_nettype none
// ============================================================================
//  Module      : p2s
//  Description : 2-bit parallel-to-serial stage. A load captures din and
//                emits din[SIN_BIT] in the next cycle, then din[COS_BIT] in
//                the cycle after, with bit_valid high for both.
//  Ports       : clk       - system clock, rising edge
//                rst       - synchronous active-low reset
//                load      - one-cycle load strobe
//                din[1:0]  - symbol to serialize
//                bit_out   - serial data
//                bit_valid - qualifier for bit_out
//  Revision    : 1.0 - initial release
// ============================================================================
module p2s
    import qam_demodulator_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] din,
    output logic       bit_out,
    output logic       bit_valid
);

    logic bit_out_q;
    logic bit_valid_q;
    logic hold_q;      // second bit waiting to be sent
    logic pend_q;      // hold_q still owes one output cycle

    always_ff @(posedge clk) begin
        if (!rst) begin
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            hold_q      <= 1'b0;
            pend_q      <= 1'b0;
        end else if (load) begin
            bit_out_q   <= din[SIN_BIT];
            bit_valid_q <= 1'b1;
            hold_q      <= din[COS_BIT];
            pend_q      <= 1'b1;
        end else if (pend_q) begin
            bit_out_q   <= hold_q;
            bit_valid_q <= 1'b1;
            pend_q      <= 1'b0;
        end else begin
            bit_valid_q <= 1'b0;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;

endmodule : p2s
`default_nettype wire

// File: rtl/qam_demodulator.sv
`default_nettype none
// ============================================================================
//  Module      : qam_demodulator
//  Description : Coherent QAM (4-point) demodulator. Correlates the received
//                samples with local sine/cosine references over SPS samples,
//                decides the sign of each correlation and serializes the
//                resulting 2-bit symbol.
//  Ports       : clk        - system clock, rising edge
//                rst        - synchronous active-low reset
//                en         - sample strobe
//                sample_in  - received signal (signed)
//                sine_in    - local sine reference (signed)
//                cosine_in  - local cosine reference (signed)
//                sym_sync   - marks this cycle as sample index 0
//                sym_out    - decided signs {sin, cos}, 1 = negative
//                sym_valid  - one-cycle pulse when sym_out updates
//                bit_out    - serialized symbol bits, sine bit first
//                bit_valid  - qualifier for bit_out
//                locked     - high once a sym_sync has been accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module qam_demodulator
    import qam_demodulator_pkg::*;
#(
    parameter int SPS   = SPS_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic [SAMPLE_W-1:0] sine_in,
    input  logic [SAMPLE_W-1:0] cosine_in,
    input  logic                sym_sync,
    output logic [1:0]          sym_out,
    output logic                sym_valid,
    output logic                bit_out,
    output logic                bit_valid,
    output logic                locked
);

    localparam int                CNT_W    = $clog2(SPS);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(SPS - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    dmd_state_e                state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [ACC_W-1:0]   sin_acc_q;
    logic signed [ACC_W-1:0]   cos_acc_q;
    logic [1:0]                sym_out_q;
    logic                      sym_valid_q;
    logic                      locked_q;

    logic signed [PROD_W-1:0]  sin_prod_d;
    logic signed [PROD_W-1:0]  cos_prod_d;
    logic signed [ACC_W-1:0]   sin_ext_d;
    logic signed [ACC_W-1:0]   cos_ext_d;
    logic signed [ACC_W-1:0]   sin_sum_d;
    logic signed [ACC_W-1:0]   cos_sum_d;

    // Products and running sums including the current sample; the decision
    // uses these so the last sample of the symbol is counted.
    always_comb begin
        sin_prod_d = $signed(sample_in) * $signed(sine_in);
        cos_prod_d = $signed(sample_in) * $signed(cosine_in);
        sin_ext_d  = {{(ACC_W-PROD_W){sin_prod_d[PROD_W-1]}}, sin_prod_d};
        cos_ext_d  = {{(ACC_W-PROD_W){cos_prod_d[PROD_W-1]}}, cos_prod_d};
        sin_sum_d  = sin_acc_q + sin_ext_d;
        cos_sum_d  = cos_acc_q + cos_ext_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_HUNT;
            cnt_q       <= '0;
            sin_acc_q   <= '0;
            cos_acc_q   <= '0;
            sym_out_q   <= 2'b00;
            sym_valid_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            if (sym_sync) begin
                // Sync always restarts the symbol, even on the last index,
                // so a coinciding boundary never produces a decision.
                state_q  <= ST_TRACK;
                locked_q <= 1'b1;
                if (en) begin
                    sin_acc_q <= sin_ext_d;
                    cos_acc_q <= cos_ext_d;
                    cnt_q     <= CNT_ONE;
                end else begin
                    sin_acc_q <= '0;
                    cos_acc_q <= '0;
                    cnt_q     <= '0;
                end
            end else if (state_q == ST_TRACK && en) begin
                if (cnt_q == LAST_IDX) begin
                    // Zero is decided as positive: only the sign bit matters.
                    sym_out_q[SIN_BIT] <= sin_sum_d[ACC_W-1];
                    sym_out_q[COS_BIT] <= cos_sum_d[ACC_W-1];
                    sym_valid_q        <= 1'b1;
                    sin_acc_q          <= '0;
                    cos_acc_q          <= '0;
                    cnt_q              <= '0;
                end else begin
                    sin_acc_q <= sin_sum_d;
                    cos_acc_q <= cos_sum_d;
                    cnt_q     <= cnt_q + CNT_ONE;
                end
            end
        end
    end

    // SPS >= 4 guarantees the two-cycle shift finishes before the next load.
    p2s u_p2s (
        .clk       (clk),
        .rst       (rst),
        .load      (sym_valid_q),
        .din       (sym_out_q),
        .bit_out   (bit_out),
        .bit_valid (bit_valid)
    );

    assign sym_out   = sym_out_q;
    assign sym_valid = sym_valid_q;
    assign locked    = locked_q;

endmodule : qam_demodulator
`default_nettype wire

// File: tb/tb_qam_demodulator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qam_demodulator
//  Description : Self-checking bench for qam_demodulator. A timeline model
//                records, per cycle, which symbol and bits must appear; the
//                DUT outputs are compared against it every cycle. A second
//                instance with SPS=256 covers the full-scale worst case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qam_demodulator;

    localparam int SPS = 16;
    localparam logic [15:0] P  = 16'h4000;   // +16384
    localparam logic [15:0] N  = 16'hC000;   // -16384
    localparam logic [15:0] SM = 16'h0100;   // +256
    localparam logic [15:0] MX = 16'h8000;   // -32768

    logic        clk = 1'b0;
    logic        rst, en, sym_sync;
    logic [15:0] sample_in, sine_in, cosine_in;
    logic [1:0]  sym_out;
    logic        sym_valid, bit_out, bit_valid, locked;

    logic        en2, sync2;
    logic [15:0] mx_in;
    logic [1:0]  sym_out2;
    logic        sym_valid2, bit_out2, bit_valid2, locked2;

    always #5 clk = ~clk;

    qam_demodulator #(.SPS(SPS), .ACC_W(40)) dut (
        .clk(clk), .rst(rst), .en(en),
        .sample_in(sample_in), .sine_in(sine_in), .cosine_in(cosine_in),
        .sym_sync(sym_sync), .sym_out(sym_out), .sym_valid(sym_valid),
        .bit_out(bit_out), .bit_valid(bit_valid), .locked(locked)
    );

    qam_demodulator #(.SPS(256), .ACC_W(40)) dut_wc (
        .clk(clk), .rst(rst), .en(en2),
        .sample_in(mx_in), .sine_in(mx_in), .cosine_in(mx_in),
        .sym_sync(sync2), .sym_out(sym_out2), .sym_valid(sym_valid2),
        .bit_out(bit_out2), .bit_valid(bit_valid2), .locked(locked2)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: symbol-level bookkeeping plus a timeline of expected
    // output events keyed by cycle number.
    bit         m_locked;
    int         m_idx;
    longint     m_sq, m_si;
    logic [1:0] m_hold;
    bit         m_rst_edge;
    logic [1:0] exp_sv [int];
    bit         exp_bv [int];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic longint prod(input logic [15:0] a, input logic [15:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    task automatic model_edge();
        int t;
        logic [1:0] s;
        t = cyc + 1;
        m_rst_edge = !rst;
        if (!rst) begin
            m_locked = 0; m_idx = 0; m_sq = 0; m_si = 0; m_hold = 2'b00;
            exp_sv.delete();
            exp_bv.delete();
        end else if (sym_sync) begin
            m_locked = 1; m_idx = 0; m_sq = 0; m_si = 0;
            if (en) begin
                m_sq  = prod(sample_in, sine_in);
                m_si  = prod(sample_in, cosine_in);
                m_idx = 1;
            end
        end else if (m_locked && en) begin
            m_sq += prod(sample_in, sine_in);
            m_si += prod(sample_in, cosine_in);
            m_idx++;
            if (m_idx == SPS) begin
                s = {m_sq < 0, m_si < 0};
                exp_sv[t]   = s;
                exp_bv[t+1] = s[1];
                exp_bv[t+2] = s[0];
                m_sq = 0; m_si = 0; m_idx = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("locked", locked, m_locked);
        if (exp_sv.exists(cyc)) begin
            chk("sym_valid", sym_valid, 1);
            chk("sym_out", sym_out, exp_sv[cyc]);
            m_hold = exp_sv[cyc];
        end else begin
            chk("sym_valid", sym_valid, 0);
            chk("sym_out_hold", sym_out, m_hold);
        end
        if (exp_bv.exists(cyc)) begin
            chk("bit_valid", bit_valid, 1);
            chk("bit_out", bit_out, exp_bv[cyc]);
        end else begin
            chk("bit_valid", bit_valid, 0);
            if (m_rst_edge) chk("bit_out_rst", bit_out, 0);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit e, input bit s, input logic [15:0] x,
                         input logic [15:0] sn, input logic [15:0] cs);
        en = e; sym_sync = s; sample_in = x; sine_in = sn; cosine_in = cs;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 16'h0, 16'h0, 16'h0);
    endtask

    initial begin
        rst = 1'b0; en = 0; sym_sync = 0;
        sample_in = 0; sine_in = 0; cosine_in = 0;
        en2 = 0; sync2 = 0; mx_in = MX;
        m_locked = 0; m_idx = 0; m_sq = 0; m_si = 0; m_hold = 0; m_rst_edge = 1;

        // Reset state, with en toggling to show it has no effect
        drive(1, 0, P, P, P);
        idle(3);
        rst = 1'b1;

        // en ignored while hunting
        for (int k = 0; k < 20; k++) drive(1, 0, P, N, N);

        // Positive cosine only -> 00, bits 0,0
        for (int k = 0; k < 16; k++) drive(1, k == 0, P, 16'h0, P);
        idle(4);

        // Negative sample against positive sine -> 10, bits 1,0
        for (int k = 0; k < 16; k++) drive(1, k == 0, N, P, 16'h0);
        idle(4);

        // en every 4th clk, symbols 00,01,10,11
        for (int s = 0; s < 4; s++) begin
            logic [1:0] sv;
            sv = 2'(s);
            for (int k = 0; k < 16; k++) begin
                drive(1, s == 0 && k == 0, P, sv[1] ? N : P, sv[0] ? N : P);
                idle(3);
            end
        end
        idle(4);

        // Resync at cnt=7: large opposite-sign partial must be discarded
        for (int k = 0; k < 7; k++) drive(1, k == 0, P, N, N);
        for (int k = 0; k < 16; k++) drive(1, k == 0, P, SM, SM);
        idle(4);

        // Sync coinciding with the last index: no decision
        for (int k = 0; k < 15; k++) drive(1, k == 0, P, P, P);
        drive(1, 1, P, N, P);
        for (int k = 0; k < 15; k++) drive(1, 0, P, N, P);
        idle(4);

        // Sync without en mid-symbol
        for (int k = 0; k < 5; k++) drive(1, k == 0, N, N, N);
        drive(0, 1, N, N, N);
        for (int k = 0; k < 16; k++) drive(1, 0, P, P, N);
        idle(4);

        // Reset at cnt=10, en in hunt, then resync
        for (int k = 0; k < 10; k++) drive(1, k == 0, P, N, N);
        rst = 1'b0; drive(1, 0, P, N, N); rst = 1'b1;
        for (int k = 0; k < 5; k++) drive(1, 0, P, N, N);
        for (int k = 0; k < 16; k++) drive(1, k == 0, P, P, N);
        idle(4);

        // Reset right after a decision aborts serialization
        for (int k = 0; k < 16; k++) drive(1, k == 0, P, N, N);
        rst = 1'b0; drive(0, 0, 16'h0, 16'h0, 16'h0); rst = 1'b1;
        idle(5);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(399) != 0);
            drive($urandom_range(1), $urandom_range(79) == 0,
                  16'($urandom), 16'($urandom), 16'($urandom));
        end
        rst = 1'b1;
        idle(4);

        // Full-scale worst case on the SPS=256 instance
        for (int k = 0; k < 256; k++) begin
            en2 = 1; sync2 = (k == 0);
            idle(1);
            if (k == 254) chk("wc_no_early", sym_valid2, 0);
            if (k == 255) begin
                chk("wc_sym_valid", sym_valid2, 1);
                chk("wc_sym_out", sym_out2, 2'b00);
            end
        end
        en2 = 0; sync2 = 0;
        idle(1);
        chk("wc_valid_drop", sym_valid2, 0);
        chk("wc_bit_valid", bit_valid2, 1);
        chk("wc_bit_out", bit_out2, 0);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_qam_demodulator
`default_nettype wire
